// File: rtl/cc_bus_arbiter.sv
// Two-core MSI coherent bus arbiter in front of a single-ported RAM; one transaction in flight.
// Optional CCARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed core-0 priority.
module cc_bus_arbiter #(
  parameter int unsigned CPUS = 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CPUS-1:0]           iren_i,
  input  logic [CPUS-1:0][31:0]     iaddr_i,
  output logic [CPUS-1:0]           iwait_o,
  output logic [CPUS-1:0][31:0]     iload_o,
  input  logic [CPUS-1:0]           dren_i,
  input  logic [CPUS-1:0]           dwen_i,
  input  logic [CPUS-1:0][31:0]     daddr_i,
  input  logic [CPUS-1:0][31:0]     dstore_i,
  output logic [CPUS-1:0]           dwait_o,
  output logic [CPUS-1:0][31:0]     dload_o,
  input  logic [CPUS-1:0]           cctrans_i,
  input  logic [CPUS-1:0]           ccwrite_i,
  output logic [CPUS-1:0]           ccwait_o,
  output logic [CPUS-1:0]           ccinv_o,
  output logic [CPUS-1:0][31:0]     ccsnoopaddr_o,
  output logic                      ramren_o,
  output logic                      ramwen_o,
  output logic [31:0]               ramaddr_o,
  output logic [31:0]               ramstore_o,
  input  logic [31:0]               ramload_i,
  input  logic                      ramwait_i
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StSnoop  = 4'd1;
  localparam logic [3:0] StRd0    = 4'd2;
  localparam logic [3:0] StRd1    = 4'd3;
  localparam logic [3:0] StWb0    = 4'd4;
  localparam logic [3:0] StWb1    = 4'd5;
  localparam logic [3:0] StC2c0   = 4'd6;
  localparam logic [3:0] StC2c1   = 4'd7;
  localparam logic [3:0] StIfetch = 4'd8;

  logic [3:0]      state_q, state_d;
  logic            grant_q, grant_d;
  logic            oth;
  logic [CPUS-1:0] dreq, cand;
  logic            pick;

  assign oth  = ~grant_q;
  assign dreq = dren_i | dwen_i | cctrans_i;
  // Any data request outranks every instruction fetch.
  assign cand = (|dreq) ? dreq : iren_i;

`ifdef CCARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  assign pick = (&cand) ? ~rr_q : cand[1];
  assign rr_d = (state_q == StIdle && |cand) ? pick : rr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  assign pick = ~cand[0];
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      StIdle: begin
        if (|cand) begin
          grant_d = pick;
          if (dreq[pick]) begin
            if (dwen_i[pick] && !cctrans_i[pick]) state_d = StWb0;
            else if (cctrans_i[pick])             state_d = StSnoop;
            else                                  state_d = StRd0;
          end else begin
            state_d = StIfetch;
          end
        end
      end
      StSnoop: begin
        if (ccwrite_i[oth])         state_d = StC2c0;
        else if (dren_i[grant_q])   state_d = StRd0;
        else                        state_d = StIdle;
      end
      StRd0:    if (!ramwait_i) state_d = StRd1;
      StRd1:    if (!ramwait_i) state_d = StIdle;
      StWb0:    if (!ramwait_i) state_d = StWb1;
      StWb1:    if (!ramwait_i) state_d = StIdle;
      StC2c0:   if (!ramwait_i) state_d = StC2c1;
      StC2c1:   if (!ramwait_i) state_d = StIdle;
      StIfetch: if (!ramwait_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    iwait_o       = '1;
    dwait_o       = '1;
    iload_o       = '0;
    dload_o       = '0;
    ccwait_o      = '0;
    ccinv_o       = '0;
    ccsnoopaddr_o = '0;
    ramren_o      = 1'b0;
    ramwen_o      = 1'b0;
    ramaddr_o     = '0;
    ramstore_o    = '0;
    case (state_q)
      StSnoop: begin
        ccwait_o[oth]      = 1'b1;
        ccinv_o[oth]       = ccwrite_i[grant_q];
        ccsnoopaddr_o[oth] = daddr_i[grant_q];
      end
      StRd0, StRd1: begin
        ramren_o          = 1'b1;
        ramaddr_o         = daddr_i[grant_q];
        dload_o[grant_q]  = ramload_i;
        dwait_o[grant_q]  = ramwait_i;
      end
      StWb0, StWb1: begin
        ramwen_o          = 1'b1;
        ramaddr_o         = daddr_i[grant_q];
        ramstore_o        = dstore_i[grant_q];
        dwait_o[grant_q]  = ramwait_i;
      end
      StC2c0, StC2c1: begin
        // M holder's write-back is forwarded to the requester while RAM absorbs it.
        ccwait_o[oth]      = 1'b1;
        ccinv_o[oth]       = ccwrite_i[grant_q];
        ccsnoopaddr_o[oth] = daddr_i[grant_q];
        ramwen_o           = 1'b1;
        ramaddr_o          = daddr_i[oth];
        ramstore_o         = dstore_i[oth];
        dload_o[grant_q]   = dstore_i[oth];
        dwait_o[grant_q]   = ramwait_i;
        dwait_o[oth]       = ramwait_i;
      end
      StIfetch: begin
        ramren_o          = 1'b1;
        ramaddr_o         = iaddr_i[grant_q];
        iload_o[grant_q]  = ramload_i;
        iwait_o[grant_q]  = ramwait_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cc_bus_arbiter.sv
// Bench for cc_bus_arbiter: directed scenarios then random transactions vs a transaction-level model.
module tb_cc_bus_arbiter;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iren, dren, dwen, cctrans, ccwrite;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic             ramwait;
  logic [31:0]      ramload;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramren, ramwen;
  logic [31:0]      ramaddr, ramstore;

  cc_bus_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iren_i(iren), .iaddr_i(iaddr), .iwait_o(iwait), .iload_o(iload),
    .dren_i(dren), .dwen_i(dwen), .daddr_i(daddr), .dstore_i(dstore),
    .dwait_o(dwait), .dload_o(dload),
    .cctrans_i(cctrans), .ccwrite_i(ccwrite), .ccwait_o(ccwait), .ccinv_o(ccinv),
    .ccsnoopaddr_o(ccsnoopaddr),
    .ramren_o(ramren), .ramwen_o(ramwen), .ramaddr_o(ramaddr), .ramstore_o(ramstore),
    .ramload_i(ramload), .ramwait_i(ramwait)
  );

  always #5 CLK = ~CLK;

  localparam int KIdle = 0, KSnoop = 1, KRd = 2, KWb = 3, KC2c = 4, KIf = 5;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_core = 1'b0;
  bit          rw_random = 1'b0;
  bit          rw_v;
  logic [31:0] ld_v, st_v;
  int          rw_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] st_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for one beat of a transaction, straight from the per-state output rules.
  task automatic check_outputs(input int kind, input bit c);
    bit               o;
    logic [1:0]       e_iw, e_dw, e_cw, e_ci;
    logic [1:0][31:0] e_il, e_dl, e_sa;
    logic             e_rr, e_rw;
    logic [31:0]      e_ad, e_st;
    o = ~c;
    e_iw = 2'b11; e_dw = 2'b11; e_cw = 2'b00; e_ci = 2'b00;
    e_il = '0; e_dl = '0; e_sa = '0;
    e_rr = 1'b0; e_rw = 1'b0; e_ad = '0; e_st = '0;
    case (kind)
      KSnoop: begin
        e_cw[o] = 1'b1; e_ci[o] = ccwrite[c]; e_sa[o] = daddr[c];
      end
      KRd: begin
        e_rr = 1'b1; e_ad = daddr[c]; e_dl[c] = ramload; e_dw[c] = ramwait;
      end
      KWb: begin
        e_rw = 1'b1; e_ad = daddr[c]; e_st = dstore[c]; e_dw[c] = ramwait;
      end
      KC2c: begin
        e_cw[o] = 1'b1; e_ci[o] = ccwrite[c];
        e_rw = 1'b1; e_ad = daddr[o]; e_st = dstore[o]; e_dl[c] = dstore[o];
        e_dw[c] = ramwait; e_dw[o] = ramwait;
      end
      KIf: begin
        e_rr = 1'b1; e_ad = iaddr[c]; e_il[c] = ramload; e_iw[c] = ramwait;
      end
      default: ;
    endcase
    chk("iwait", 64'(iwait), 64'(e_iw));
    chk("dwait", 64'(dwait), 64'(e_dw));
    chk("ccwait", 64'(ccwait), 64'(e_cw));
    chk("ccinv", 64'(ccinv), 64'(e_ci));
    chk("ramREN", 64'(ramren), 64'(e_rr));
    chk("ramWEN", 64'(ramwen), 64'(e_rw));
    chk("ramaddr", 64'(ramaddr), 64'(e_ad));
    chk("ramstore", 64'(ramstore), 64'(e_st));
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    if (kind != KC2c) chk("ccsnoopaddr", ccsnoopaddr, e_sa);
  endtask

  // One clock cycle: drive RAM inputs, check at negedge, return whether the beat completes.
  task automatic cycle(input int kind, input bit c, output bit adv);
    if (kind != KIdle && kind != KSnoop && rw_q.size() > 0) rw_v = rw_q.pop_front() != 0;
    else rw_v = rw_random ? ($urandom_range(0, 3) == 0) : 1'b0;
    ramwait = rw_v;
    if (ld_q.size() > 0) ld_v = ld_q.pop_front();
    else ld_v = $urandom;
    ramload = ld_v;
    @(negedge CLK);
    check_outputs(kind, c);
    adv = (kind == KSnoop) || !ramwait;
    @(posedge CLK);
    #1;
    if (adv && kind == KWb) begin
      st_v = (st_q.size() > 0) ? st_q.pop_front() : $urandom;
      dstore[c] = st_v;
    end else if (adv && kind == KC2c) begin
      st_v = (st_q.size() > 0) ? st_q.pop_front() : $urandom;
      dstore[~c] = st_v;
    end
  endtask

  task automatic clear_reqs();
    iren = '0; dren = '0; dwen = '0; cctrans = '0; ccwrite = '0;
  endtask

  // 0 none, 1 ifetch, 2 read miss, 3 upgrade, 4 eviction; extra iREN and M-state bit are random.
  task automatic set_core(input bit c, input int k);
    iren[c]    = (k == 1) || ($urandom_range(0, 2) == 0);
    dren[c]    = (k == 2);
    cctrans[c] = (k == 2) || (k == 3);
    dwen[c]    = (k == 4);
    ccwrite[c] = (k == 3) || ($urandom_range(0, 1) == 1);
    iaddr[c]   = $urandom & 32'hffff_fffc;
    daddr[c]   = $urandom & 32'hffff_fffc;
    dstore[c]  = $urandom;
  endtask

  // Transaction-level model: pick a winner, expand its transaction into beats, then walk them.
  task automatic run_txn();
    logic [1:0] dreq, cand;
    bit         win, o, adv;
    int         beats[$];
    int         idx, guard;
    dreq = dren | dwen | cctrans;
    cand = (dreq != 2'b00) ? dreq : iren;
    win = 1'b0;
    if (cand == 2'b11) begin
`ifdef CCARB_ROUND_ROBIN_EN
      win = ~last_core;
`else
      win = 1'b0;
`endif
    end else if (cand == 2'b10) begin
      win = 1'b1;
    end
    o = ~win;
    if (cand != 2'b00) begin
      if (dreq[win]) begin
        if (dwen[win] && !cctrans[win]) begin
          beats.push_back(KWb); beats.push_back(KWb);
        end else if (cctrans[win]) begin
          beats.push_back(KSnoop);
          if (ccwrite[o]) begin
            beats.push_back(KC2c); beats.push_back(KC2c);
          end else if (dren[win]) begin
            beats.push_back(KRd); beats.push_back(KRd);
          end
        end else begin
          beats.push_back(KRd); beats.push_back(KRd);
        end
      end else begin
        beats.push_back(KIf);
      end
      last_core = win;
    end
    cycle(KIdle, win, adv);
    idx = 0;
    guard = 0;
    while (idx < beats.size()) begin
      if (guard > 200) begin
        n_checks++;
        n_fail++;
        $error("FAIL txn_bound: observed %0d beats done expected %0d", idx, beats.size());
        break;
      end
      guard++;
      cycle(beats[idx], win, adv);
      if (adv) idx++;
    end
    clear_reqs();
  endtask

  bit adv0;

  initial begin
    nRST = 1'b0;
    clear_reqs();
    iaddr = '0; daddr = '0; dstore = '0;
    ramwait = 1'b0; ramload = 32'h0;
    #3;
    check_outputs(KIdle, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cycle(KIdle, 1'b0, adv0);

    // Read miss, no M holder.
    set_core(1'b0, 2); set_core(1'b1, 0);
    iren = '0; ccwrite = 2'b00; daddr[0] = 32'h100;
    ld_q = '{32'h0, 32'h0, 32'hA, 32'hB};
    run_txn();

    // Cache-to-cache from core1 in M.
    set_core(1'b0, 2); set_core(1'b1, 0);
    iren = '0; ccwrite = 2'b11; dstore[1] = 32'h11;
    st_q = '{32'h22};
    run_txn();

    // Eviction with RAM stalls.
    set_core(1'b0, 0); set_core(1'b1, 4);
    iren = '0; daddr[1] = 32'h208;
    rw_q = '{1, 1, 1, 0, 0};
    run_txn();

    // Data beats fetch; then repeated fetch ties.
    set_core(1'b0, 1); set_core(1'b1, 2);
    iren = 2'b11;
    run_txn();
    set_core(1'b0, 1); set_core(1'b1, 1);
    run_txn();
    set_core(1'b0, 1); set_core(1'b1, 1);
    run_txn();

    // Reset during C2C0.
    set_core(1'b0, 2); set_core(1'b1, 0);
    iren = '0; ccwrite = 2'b11;
    cycle(KIdle, 1'b0, adv0);
    cycle(KSnoop, 1'b0, adv0);
    nRST = 1'b0;
    #1;
    check_outputs(KIdle, 1'b0);
    last_core = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    clear_reqs();
    cycle(KIdle, 1'b0, adv0);
    cycle(KIdle, 1'b0, adv0);

    rw_random = 1'b1;
    for (int t = 0; t < 150; t++) begin
      set_core(1'b0, int'($urandom_range(0, 4)));
      set_core(1'b1, int'($urandom_range(0, 4)));
      run_txn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
